// File: rtl/vga_pkg.sv
// Shared types and colour constants for the sprite bouncer pixel stage.
package vga_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic {POS = 1'b0, NEG = 1'b1} dir_t;

   localparam logic [9:0] PIX_INVALID = 10'h3FF;

   localparam rgb_t BG_LIGHT = '{r: 8'h60, g: 8'h60, b: 8'h60};
   localparam rgb_t BG_DARK  = '{r: 8'h20, g: 8'h20, b: 8'h20};

   // Red, orange, yellow, green, cyan, blue, magenta, white.
   localparam rgb_t PALETTE [0:7] = '{
      '{r: 8'hFF, g: 8'h00, b: 8'h00},
      '{r: 8'hFF, g: 8'h80, b: 8'h00},
      '{r: 8'hFF, g: 8'hFF, b: 8'h00},
      '{r: 8'h00, g: 8'hFF, b: 8'h00},
      '{r: 8'h00, g: 8'hFF, b: 8'hFF},
      '{r: 8'h00, g: 8'h00, b: 8'hFF},
      '{r: 8'hFF, g: 8'h00, b: 8'hFF},
      '{r: 8'hFF, g: 8'hFF, b: 8'hFF}
   };

endpackage

// File: rtl/sprite_axis_mover.sv
// One axis of sprite motion: position register plus POS/NEG direction FSM.
module sprite_axis_mover
   import vga_pkg::*;
#(
   parameter int LIMIT = 608,
   parameter int START = 0
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tick,
   input  logic [2:0] step,
   output logic [9:0] pos,
   output logic       hit
);

   localparam logic [10:0] LIM = 11'(LIMIT);

   dir_t        r_dir;
   dir_t        w_dir_nxt;
   logic [9:0]  r_pos;
   logic [9:0]  w_pos_nxt;
   logic [10:0] w_sum;

   // 11-bit sum so a step past the far edge cannot wrap.
   assign w_sum = {1'b0, r_pos} + {8'd0, step};

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_dir <= POS;
         r_pos <= 10'(START);
      end else begin
         r_dir <= w_dir_nxt;
         r_pos <= w_pos_nxt;
      end
   end

   always_comb begin
      w_dir_nxt = r_dir;
      w_pos_nxt = r_pos;
      hit       = 1'b0;
      if (tick) begin
         case (r_dir)
            POS: begin
               if (w_sum >= LIM) begin
                  w_pos_nxt = LIM[9:0];
                  w_dir_nxt = NEG;
                  hit       = 1'b1;
               end else begin
                  w_pos_nxt = w_sum[9:0];
               end
            end
            NEG: begin
               if (r_pos <= {7'd0, step}) begin
                  w_pos_nxt = '0;
                  w_dir_nxt = POS;
                  hit       = 1'b1;
               end else begin
                  w_pos_nxt = r_pos - {7'd0, step};
               end
            end
            default: ;
         endcase
      end
   end

   assign pos = r_pos;

endmodule

// File: rtl/vga_sprite_bouncer.sv
// Pixel-colour stage: checkerboard background with one bouncing, colour-cycling sprite.
module vga_sprite_bouncer
   import vga_pkg::*;
#(
   parameter int SPRITE_W = 32,
   parameter int SPRITE_H = 32,
   parameter int H_VIS    = 640,
   parameter int V_VIS    = 480,
   parameter int START_X  = 0,
   parameter int START_Y  = 0
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [9:0] hPix,
   input  logic [9:0] vPix,
   input  logic       n_blank,
   input  logic       v_sync,
   input  logic       vga_clk,
   input  logic [1:0] speed,
   input  logic       pause,
   output logic [7:0] red,
   output logic [7:0] green,
   output logic [7:0] blue,
   output logic [7:0] bounce_count
);

   logic       r_v_sync_d;
   logic       w_frame_tick;
   logic       w_tick;
   logic [2:0] w_step;
   logic [9:0] w_x;
   logic [9:0] w_y;
   logic       w_hit_x;
   logic       w_hit_y;
   logic [2:0] r_idx;
   logic [7:0] r_bounce;
   logic       w_in_x;
   logic       w_in_y;
   rgb_t       w_pix;
   rgb_t       r_rgb;

   assign w_frame_tick = r_v_sync_d & ~v_sync;
   assign w_tick       = w_frame_tick & ~pause;
   assign w_step       = {1'b0, speed} + 3'd1;

   sprite_axis_mover #(.LIMIT(H_VIS - SPRITE_W), .START(START_X)) u_mover_x (
      .clk   (clk),
      .n_rst (n_rst),
      .tick  (w_tick),
      .step  (w_step),
      .pos   (w_x),
      .hit   (w_hit_x)
   );

   sprite_axis_mover #(.LIMIT(V_VIS - SPRITE_H), .START(START_Y)) u_mover_y (
      .clk   (clk),
      .n_rst (n_rst),
      .tick  (w_tick),
      .step  (w_step),
      .pos   (w_y),
      .hit   (w_hit_y)
   );

   // A corner hit is a single bounce.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_v_sync_d <= 1'b1;
         r_idx      <= '0;
         r_bounce   <= '0;
      end else begin
         r_v_sync_d <= v_sync;
         if (w_hit_x | w_hit_y) begin
            r_idx    <= r_idx + 3'd1;
            r_bounce <= r_bounce + 8'd1;
         end
      end
   end

   assign w_in_x = ({1'b0, hPix} >= {1'b0, w_x}) &&
                   ({1'b0, hPix} <  ({1'b0, w_x} + 11'(SPRITE_W)));
   assign w_in_y = ({1'b0, vPix} >= {1'b0, w_y}) &&
                   ({1'b0, vPix} <  ({1'b0, w_y} + 11'(SPRITE_H)));

   always_comb begin
      w_pix = '0;
      if (n_blank && (hPix != PIX_INVALID) && (vPix != PIX_INVALID)) begin
         if (w_in_x && w_in_y) begin
            w_pix = PALETTE[r_idx];
         end else if (hPix[5] ^ vPix[5]) begin
            w_pix = BG_LIGHT;
         end else begin
            w_pix = BG_DARK;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_rgb <= '0;
      end else if (vga_clk) begin
         r_rgb <= w_pix;
      end
   end

   assign red          = r_rgb.r;
   assign green        = r_rgb.g;
   assign blue         = r_rgb.b;
   assign bounce_count = r_bounce;

endmodule
